// File: rtl/micro_cnt_checker.sv
// Locks onto a free-running +1 ramp from the micro-tile output bus and keeps
// saturating match/mismatch statistics once the ramp is being tracked.
module micro_cnt_checker #(
   parameter int WIDTH       = 8,
   parameter int ERR_W       = 16,
   parameter int LOCK_RUN    = 4,
   parameter int LOSS_THRESH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             clr_stats,
   input  logic [WIDTH-1:0] tile_out,
   output logic             locked,
   output logic             sticky_err,
   output logic [ERR_W-1:0] err_cnt,
   output logic [ERR_W-1:0] match_cnt,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEED  = 2'd1,
      SYNC  = 2'd2,
      TRACK = 2'd3
   } state_e;

   localparam logic [ERR_W-1:0] CNT_MAX = {ERR_W{1'b1}};

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sample_q;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [3:0]       run_q, run_d;
   logic [3:0]       miss_q, miss_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic [ERR_W-1:0] match_q, match_d;
   logic             sticky_q, sticky_d;
   logic             locked_q, locked_d;

   logic [WIDTH-1:0] prev_inc;
   logic             step_ok;
   logic [3:0]       run_inc;
   logic [3:0]       miss_inc;
   logic             lock_hit;
   logic             loss_hit;
   logic             inc_err;
   logic             inc_match;

   assign prev_inc = prev_q + WIDTH'(1);
   assign step_ok  = (sample_q == prev_inc);
   assign run_inc  = step_ok ? (run_q + 4'd1) : 4'd0;
   assign miss_inc = miss_q + 4'd1;
   assign lock_hit = (run_inc == 4'(LOCK_RUN));
   assign loss_hit = (miss_inc == 4'(LOSS_THRESH));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    state_d = SEED;
            SEED:    state_d = SYNC;
            SYNC:    if (lock_hit) state_d = TRACK;
            TRACK:   if (!step_ok && loss_hit) state_d = SYNC;
            default: state_d = IDLE;
         endcase
      end
   end

   // Datapath next values; enable low freezes everything except the FSM.
   always_comb begin
      prev_d    = prev_q;
      run_d     = run_q;
      miss_d    = miss_q;
      inc_err   = 1'b0;
      inc_match = 1'b0;
      if (enable) begin
         case (state_q)
            SEED: begin
               prev_d = sample_q;
               run_d  = 4'd0;
            end
            SYNC: begin
               prev_d = sample_q;
               run_d  = run_inc;
               if (lock_hit) miss_d = 4'd0;
            end
            TRACK: begin
               if (step_ok) begin
                  inc_match = 1'b1;
                  miss_d    = 4'd0;
                  prev_d    = sample_q;
               end else begin
                  // Flywheel the expected value so one glitch costs one error.
                  inc_err = 1'b1;
                  miss_d  = miss_inc;
                  prev_d  = prev_inc;
                  if (loss_hit) begin
                     run_d  = 4'd0;
                     miss_d = 4'd0;
                     prev_d = sample_q;
                  end
               end
            end
            default: ;
         endcase
      end

      err_d    = err_q;
      match_d  = match_q;
      sticky_d = sticky_q | inc_err;
      if (inc_err && (err_q != CNT_MAX))     err_d   = err_q + ERR_W'(1);
      if (inc_match && (match_q != CNT_MAX)) match_d = match_q + ERR_W'(1);
      if (clr_stats) begin
         err_d    = '0;
         match_d  = '0;
         sticky_d = 1'b0;
      end
      locked_d = (state_d == TRACK);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sample_q <= '0;
         prev_q   <= '0;
         run_q    <= '0;
         miss_q   <= '0;
         err_q    <= '0;
         match_q  <= '0;
         sticky_q <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         sample_q <= tile_out;
         prev_q   <= prev_d;
         run_q    <= run_d;
         miss_q   <= miss_d;
         err_q    <= err_d;
         match_q  <= match_d;
         sticky_q <= sticky_d;
         locked_q <= locked_d;
      end
   end

   assign locked     = locked_q;
   assign sticky_err = sticky_q;
   assign err_cnt    = err_q;
   assign match_cnt  = match_q;
   assign state      = state_q;

endmodule

// File: tb/tb_micro_cnt_checker.sv
// Scenario bench for micro_cnt_checker: default instance plus a narrow-counter,
// high-loss-threshold instance used for saturation and clear checks.
module tb_micro_cnt_checker;

   localparam int LR = 4;

   typedef struct packed {
      logic [1:0]  st;
      logic        lk;
      logic [15:0] err;
      logic [15:0] mat;
      logic        sk;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst, enable, clr_stats;
   logic [7:0]  tile_out;

   logic        locked, sticky_err;
   logic [15:0] err_cnt, match_cnt;
   logic [1:0]  state;

   logic        b_locked, b_sticky;
   logic [3:0]  b_err, b_match;
   logic [1:0]  b_state;

   int   n_tests = 0;
   int   n_fail  = 0;
   obs_t exp_q[$];

   always #5 clk = ~clk;

   micro_cnt_checker #(.WIDTH(8), .ERR_W(16), .LOCK_RUN(4), .LOSS_THRESH(3)) dut (
      .clk(clk), .rst(rst), .enable(enable), .clr_stats(clr_stats), .tile_out(tile_out),
      .locked(locked), .sticky_err(sticky_err), .err_cnt(err_cnt),
      .match_cnt(match_cnt), .state(state)
   );

   micro_cnt_checker #(.WIDTH(8), .ERR_W(4), .LOCK_RUN(4), .LOSS_THRESH(15)) dut_sat (
      .clk(clk), .rst(rst), .enable(enable), .clr_stats(clr_stats), .tile_out(tile_out),
      .locked(b_locked), .sticky_err(b_sticky), .err_cnt(b_err),
      .match_cnt(b_match), .state(b_state)
   );

   task automatic tick(input logic r, input logic e, input logic c, input logic [7:0] t);
      rst = r; enable = e; clr_stats = c; tile_out = t;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      obs_t ex, got;
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back('{st:2'd0, lk:1'b0, err:16'd0, mat:16'd0, sk:1'b0});
         tick(k == 0, k == 0, 1'b0, 8'h33 + 8'(k));
         ex  = exp_q.pop_front();
         got = '{st:state, lk:locked, err:err_cnt, mat:match_cnt, sk:sticky_err};
         n_tests++;
         if (got !== ex) begin
            n_fail++;
            $display("FAIL reset[%0d]: got st=%0d lk=%0b err=%0d mat=%0d sk=%0b, want st=%0d lk=%0b err=%0d mat=%0d sk=%0b",
                     k, got.st, got.lk, got.err, got.mat, got.sk, ex.st, ex.lk, ex.err, ex.mat, ex.sk);
         end else $display("[TB] reset[%0d] st=%0d ok", k, got.st);
      end
   endtask

   // Reset, then a clean ramp from base; lock lands 1+LR edges after SEED entry.
   task automatic test_lock_ramp(input logic [7:0] base, input int n, input string tag);
      obs_t ex, got;
      for (int k = -1; k < n; k++) begin
         ex.st  = (k < 0) ? 2'd0 : (k == 0) ? 2'd1 : (k < 1 + LR) ? 2'd2 : 2'd3;
         ex.lk  = (k >= 1 + LR);
         ex.err = 16'd0;
         ex.mat = (k >= 1 + LR) ? 16'(k - (1 + LR)) : 16'd0;
         ex.sk  = 1'b0;
         exp_q.push_back(ex);
         if (k < 0) tick(1'b1, 1'b0, 1'b0, 8'h00);
         else       tick(1'b0, 1'b1, 1'b0, base + 8'(k));
         ex  = exp_q.pop_front();
         got = '{st:state, lk:locked, err:err_cnt, mat:match_cnt, sk:sticky_err};
         n_tests++;
         if (got !== ex) begin
            n_fail++;
            $display("FAIL %s[%0d]: got st=%0d lk=%0b err=%0d mat=%0d sk=%0b, want st=%0d lk=%0b err=%0d mat=%0d sk=%0b",
                     tag, k, got.st, got.lk, got.err, got.mat, got.sk, ex.st, ex.lk, ex.err, ex.mat, ex.sk);
         end else $display("[TB] %s[%0d] tile=%h st=%0d mat=%0d ok", tag, k, tile_out, got.st, got.mat);
      end
   endtask

   // Continues a lock from base 0x30 with 16 ramp steps (match=10, next tile 0x40).
   task automatic test_glitch();
      obs_t ex, got;
      logic [7:0] gl [7];
      gl = '{8'h40, 8'h41, 8'hAA, 8'h43, 8'h44, 8'h45, 8'h46};
      for (int j = 0; j < 7; j++) begin
         ex = '{st:2'd3, lk:1'b1, err:16'((j >= 3) ? 1 : 0),
                mat:16'(11 + j - ((j >= 3) ? 1 : 0)), sk:(j >= 3)};
         exp_q.push_back(ex);
         tick(1'b0, 1'b1, 1'b0, gl[j]);
         ex  = exp_q.pop_front();
         got = '{st:state, lk:locked, err:err_cnt, mat:match_cnt, sk:sticky_err};
         n_tests++;
         if (got !== ex) begin
            n_fail++;
            $display("FAIL glitch[%0d]: got st=%0d lk=%0b err=%0d mat=%0d sk=%0b, want st=%0d lk=%0b err=%0d mat=%0d sk=%0b",
                     j, got.st, got.lk, got.err, got.mat, got.sk, ex.st, ex.lk, ex.err, ex.mat, ex.sk);
         end else $display("[TB] glitch[%0d] tile=%h err=%0d mat=%0d ok", j, gl[j], got.err, got.mat);
      end
   endtask

   // First row clears stats while a match is due (clear must win), then
   // three zero samples drop lock and a ramp from 0x50 re-acquires it.
   task automatic test_loss_relock();
      obs_t ex, got;
      logic [7:0] tl [12];
      int st [12], er [12], mt [12], sk [12];
      tl = '{8'h47, 8'h48, 8'h00, 8'h00, 8'h00, 8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56};
      st = '{3, 3, 3, 3, 3, 2, 2, 2, 2, 2, 3, 3};
      er = '{0, 0, 0, 1, 2, 3, 3, 3, 3, 3, 3, 3};
      mt = '{0, 1, 2, 2, 2, 2, 2, 2, 2, 2, 2, 3};
      sk = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
      for (int i = 0; i < 12; i++) begin
         ex = '{st:2'(st[i]), lk:(st[i] == 3), err:16'(er[i]), mat:16'(mt[i]), sk:(sk[i] != 0)};
         exp_q.push_back(ex);
         tick(1'b0, 1'b1, i == 0, tl[i]);
         ex  = exp_q.pop_front();
         got = '{st:state, lk:locked, err:err_cnt, mat:match_cnt, sk:sticky_err};
         n_tests++;
         if (got !== ex) begin
            n_fail++;
            $display("FAIL loss_relock[%0d]: got st=%0d lk=%0b err=%0d mat=%0d sk=%0b, want st=%0d lk=%0b err=%0d mat=%0d sk=%0b",
                     i, got.st, got.lk, got.err, got.mat, got.sk, ex.st, ex.lk, ex.err, ex.mat, ex.sk);
         end else $display("[TB] loss_relock[%0d] tile=%h st=%0d err=%0d ok", i, tl[i], got.st, got.err);
      end
   endtask

   // Disable in TRACK holds stats, re-enable relocks, two glitches bring
   // err to 5, then reset clears everything and enable starts SEED again.
   task automatic test_enable_reset();
      obs_t ex, got;
      logic [7:0] tl [15];
      int en [15], st [15], er [15], mt [15];
      tl = '{8'h57, 8'h58, 8'h59, 8'h5A, 8'h5B, 8'h5C, 8'h5D, 8'h5E, 8'hAA, 8'h60,
             8'hAA, 8'h62, 8'h63, 8'h64, 8'h65};
      en = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
      st = '{0, 0, 1, 2, 2, 2, 2, 3, 3, 3, 3, 3, 3, 0, 1};
      er = '{3, 3, 3, 3, 3, 3, 3, 3, 3, 4, 4, 5, 5, 0, 0};
      mt = '{3, 3, 3, 3, 3, 3, 3, 3, 4, 4, 5, 5, 6, 0, 0};
      for (int i = 0; i < 15; i++) begin
         ex = '{st:2'(st[i]), lk:(st[i] == 3), err:16'(er[i]), mat:16'(mt[i]), sk:(i < 13)};
         exp_q.push_back(ex);
         tick(i == 13, en[i] != 0, 1'b0, tl[i]);
         ex  = exp_q.pop_front();
         got = '{st:state, lk:locked, err:err_cnt, mat:match_cnt, sk:sticky_err};
         n_tests++;
         if (got !== ex) begin
            n_fail++;
            $display("FAIL enable_reset[%0d]: got st=%0d lk=%0b err=%0d mat=%0d sk=%0b, want st=%0d lk=%0b err=%0d mat=%0d sk=%0b",
                     i, got.st, got.lk, got.err, got.mat, got.sk, ex.st, ex.lk, ex.err, ex.mat, ex.sk);
         end else $display("[TB] enable_reset[%0d] st=%0d err=%0d mat=%0d ok", i, got.st, got.err, got.mat);
      end
   endtask

   // Narrow instance: 14 misses, one good step, 10 more misses; err pins at 15,
   // and a clear on a mismatch cycle leaves 0 rather than 1.
   task automatic test_saturation();
      obs_t ex, got;
      int   e_err = 0, e_mat = 0;
      logic e_sk  = 1'b0;
      logic [7:0] t;
      bit   bad_prev;
      for (int k = -1; k < 32; k++) begin
         if (k >= 1 + LR + 1) begin
            bad_prev = ((k - 1) >= 6 && (k - 1) <= 19) || ((k - 1) >= 21 && (k - 1) <= 30);
            if (bad_prev) begin
               e_err = (e_err < 15) ? e_err + 1 : 15;
               e_sk  = 1'b1;
            end else begin
               e_mat = (e_mat < 15) ? e_mat + 1 : 15;
            end
         end
         if (k == 25) begin
            e_err = 0; e_mat = 0; e_sk = 1'b0;
         end
         ex.st  = (k < 0) ? 2'd0 : (k == 0) ? 2'd1 : (k < 1 + LR) ? 2'd2 : 2'd3;
         ex.lk  = (k >= 1 + LR);
         ex.err = 16'(e_err);
         ex.mat = 16'(e_mat);
         ex.sk  = e_sk;
         exp_q.push_back(ex);
         t = (((k >= 6) && (k <= 19)) || ((k >= 21) && (k <= 30))) ? 8'h00 : 8'h20 + 8'(k);
         if (k < 0) tick(1'b1, 1'b0, 1'b0, 8'h00);
         else       tick(1'b0, 1'b1, k == 25, t);
         ex  = exp_q.pop_front();
         got = '{st:b_state, lk:b_locked, err:{12'd0, b_err}, mat:{12'd0, b_match}, sk:b_sticky};
         n_tests++;
         if (got !== ex) begin
            n_fail++;
            $display("FAIL saturation[%0d]: got st=%0d lk=%0b err=%0d mat=%0d sk=%0b, want st=%0d lk=%0b err=%0d mat=%0d sk=%0b",
                     k, got.st, got.lk, got.err, got.mat, got.sk, ex.st, ex.lk, ex.err, ex.mat, ex.sk);
         end else $display("[TB] saturation[%0d] tile=%h err=%0d mat=%0d ok", k, t, got.err, got.mat);
      end
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; clr_stats = 1'b0; tile_out = 8'h00;
      test_reset();
      test_lock_ramp(8'h10, 12, "clean_lock");
      test_lock_ramp(8'hF0, 22, "wrap");
      test_lock_ramp(8'h30, 16, "glitch_setup");
      test_glitch();
      test_loss_relock();
      test_enable_reset();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
